// File: rtl/imem_loader.sv
// imem_loader: reloads the CPU instruction memory from a byte stream.
// Optional checksum trailer is built in when IMEM_LOADER_CSUM_EN is defined.
module imem_loader #(
    parameter int unsigned NUM_WORDS_IMEM = 8192,
    parameter logic [31:0] MAGIC          = 32'hC0DE_F00D,
    parameter int unsigned TIMEOUT_CYC    = 1_000_000
) (
    input  logic        i_clk,
    input  logic        i_arst_n,
    input  logic        i_rx_vld,
    output logic        o_rx_rdy,
    input  logic [7:0]  i_rx_dat,
    output logic        o_imem_we,
    output logic [29:0] o_imem_waddr,
    output logic [31:0] o_imem_wdat,
    output logic        o_cpu_rst_n,
    output logic        o_busy,
    output logic        o_done,
    output logic [1:0]  o_err
);

    localparam int IW = $clog2(NUM_WORDS_IMEM) + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [31:0]   MAXLEN   = 32'(NUM_WORDS_IMEM);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

`ifdef IMEM_LOADER_CSUM_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LEN  = 2'd1,
        S_DATA = 2'd2,
        S_CSUM = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LEN  = 2'd1,
        S_DATA = 2'd2
    } state_t;
`endif

    state_t        r_state;
    state_t        w_state_nxt;

    logic [31:0]   r_shift;
    logic [1:0]    r_bcnt;
    logic [IW-1:0] r_len;
    logic [IW-1:0] r_widx;
    logic [TW-1:0] r_tcnt;

    logic          r_rx_rdy;
    logic          r_we;
    logic [29:0]   r_waddr;
    logic [31:0]   r_wdat;
    logic          r_cpu_rst_n;
    logic          r_done;
    logic [1:0]    r_err;

`ifdef IMEM_LOADER_CSUM_EN
    logic [31:0]   r_sum;
`endif

    logic          w_acc;
    logic [31:0]   w_shift_nxt;
    logic          w_word_rdy;
    logic          w_tmo;
    logic          w_len_bad;
    logic          w_last_word;
    logic          w_leave;

    logic          w_wr;
    logic          w_done_set;
    logic [1:0]    w_err_nxt;
    logic          w_cpu_nxt;

    // Every byte offered while ready is consumed in the same cycle.
    assign w_acc = i_rx_vld & r_rx_rdy;

    // New bytes enter at the top, so after four bytes the
    // register holds the little-endian word.
    assign w_shift_nxt = {i_rx_dat, r_shift[31:8]};

    assign w_word_rdy = w_acc & (r_bcnt == 2'd3);

    // Inter-byte gap expires on the edge the count would reach TIMEOUT_CYC.
    assign w_tmo = (r_state != S_IDLE)
                 & ~w_acc
                 & (r_tcnt == TMO_LAST);

    assign w_len_bad = (w_shift_nxt == 32'd0)
                     | (w_shift_nxt > MAXLEN);

    assign w_last_word = (r_widx == (r_len - IW'(1)));

    assign w_leave = (w_state_nxt != r_state);

    assign o_rx_rdy     = r_rx_rdy;
    assign o_imem_we    = r_we;
    assign o_imem_waddr = r_waddr;
    assign o_imem_wdat  = r_wdat;
    assign o_cpu_rst_n  = r_cpu_rst_n;
    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = r_done;
    assign o_err        = r_err;

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_arst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus the status/strobe decisions for this edge.
    always_comb begin
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        w_done_set  = 1'b0;
        w_err_nxt   = r_err;
        w_cpu_nxt   = r_cpu_rst_n;

        if (!r_rx_rdy) begin
            w_cpu_nxt = 1'b1;
        end

        if (w_tmo) begin
            w_state_nxt = S_IDLE;
            w_err_nxt   = 2'b10;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_acc && (w_shift_nxt == MAGIC)) begin
                        w_state_nxt = S_LEN;
                        w_cpu_nxt   = 1'b0;
                        w_err_nxt   = 2'b00;
                    end
                end
                S_LEN: begin
                    if (w_word_rdy) begin
                        if (w_len_bad) begin
                            w_state_nxt = S_IDLE;
                            w_err_nxt   = 2'b01;
                            w_cpu_nxt   = 1'b1;
                        end else begin
                            w_state_nxt = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_word_rdy) begin
                        w_wr = 1'b1;
                        if (w_last_word) begin
`ifdef IMEM_LOADER_CSUM_EN
                            w_state_nxt = S_CSUM;
`else
                            w_state_nxt = S_IDLE;
                            w_done_set  = 1'b1;
                            w_cpu_nxt   = 1'b1;
`endif
                        end
                    end
                end
`ifdef IMEM_LOADER_CSUM_EN
                S_CSUM: begin
                    if (w_word_rdy) begin
                        w_state_nxt = S_IDLE;
                        if (w_shift_nxt == r_sum) begin
                            w_done_set = 1'b1;
                            w_cpu_nxt  = 1'b1;
                        end else begin
                            w_err_nxt = 2'b11;
                        end
                    end
                end
`endif
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Byte assembly, counters and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_arst_n) begin
            r_shift     <= 32'd0;
            r_bcnt      <= 2'd0;
            r_len       <= '0;
            r_widx      <= '0;
            r_tcnt      <= '0;
            r_rx_rdy    <= 1'b0;
            r_we        <= 1'b0;
            r_waddr     <= 30'd0;
            r_wdat      <= 32'd0;
            r_cpu_rst_n <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 2'b00;
        end else begin
            r_rx_rdy    <= 1'b1;
            r_we        <= w_wr;
            r_done      <= w_done_set;
            r_err       <= w_err_nxt;
            r_cpu_rst_n <= w_cpu_nxt;

            // Clearing on every state change keeps stale payload
            // bytes from completing a header match later.
            if (w_leave) begin
                r_shift <= 32'd0;
            end else if (w_acc) begin
                r_shift <= w_shift_nxt;
            end

            if (w_leave) begin
                r_bcnt <= 2'd0;
            end else if (w_acc && (r_state != S_IDLE)) begin
                r_bcnt <= r_bcnt + 2'd1;
            end

            if ((r_state == S_LEN) && w_word_rdy) begin
                r_len <= w_shift_nxt[IW-1:0];
            end

            if (r_state == S_LEN) begin
                r_widx <= '0;
            end else if (w_wr) begin
                r_widx <= r_widx + IW'(1);
            end

            if ((r_state == S_IDLE) || w_acc || (w_state_nxt == S_IDLE)) begin
                r_tcnt <= '0;
            end else begin
                r_tcnt <= r_tcnt + TW'(1);
            end

            if (w_wr) begin
                r_waddr <= 30'(r_widx);
                r_wdat  <= w_shift_nxt;
            end
        end
    end

`ifdef IMEM_LOADER_CSUM_EN
    // Running sum of the payload words for the trailer compare.
    always_ff @(posedge i_clk) begin
        if (!i_arst_n) begin
            r_sum <= 32'd0;
        end else if (r_state == S_LEN) begin
            r_sum <= 32'd0;
        end else if (w_wr) begin
            r_sum <= r_sum + w_shift_nxt;
        end
    end
`endif

endmodule
